// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Imported by the channel and the top.
package button_debouncer_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

  localparam int DEB_DEFAULT_CYCLES = 500000;
  localparam int DEB_DEFAULT_WIDTH  = 2;

  function automatic int deb_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button bit: 2-flop synchroniser, stability FSM,
// level register and registered press/release pulses.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
  parameter logic RESET_VALUE     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic settling
);

  localparam int CW = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  deb_state_t    state_q;
  deb_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic          release_q;
  logic          release_d;
  logic          settling_q;
  logic          settling_d;
  logic          glitch;
  logic          done;
  logic          step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= RESET_VALUE;
      sync2      <= RESET_VALUE;
      state_q    <= STABLE;
      cnt_q      <= '0;
      level_q    <= RESET_VALUE;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      sync1      <= button_raw;
      sync2      <= sync1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      settling_q <= settling_d;
    end
  end

  assign glitch = (sync2 == level_q);
  assign done   = !glitch && (cnt_q == CNT_LAST);
  assign step   = !glitch && (cnt_q != CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      STABLE: begin
        if (sync2 != level_q) begin
          // A one-cycle window needs no counting state.
          if (DEBOUNCE_CYCLES == 1) begin
            level_d = sync2;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = SETTLING;
          end
        end
      end
      SETTLING: begin
        unique case (1'b1)
          glitch: begin
            cnt_d   = '0;
            state_d = STABLE;
          end
          done: begin
            level_d = sync2;
            cnt_d   = '0;
            state_d = STABLE;
          end
          step: begin
            cnt_d = cnt_q + CNT_ONE;
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
      default: begin
        state_d = STABLE;
      end
    endcase
  end

  always_comb begin
    press_d    = level_q & ~level_d;
    release_d  = ~level_q & level_d;
    settling_d = (state_d == SETTLING);
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign settling      = settling_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner feeding the PIO in_port.
// Channels are independent debounce_channel instances.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int               WIDTH           = DEB_DEFAULT_WIDTH,
  parameter int               DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] button_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] settling
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .button_raw    (button_raw[i]),
      .button_level  (button_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .settling      (settling[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: two debouncers (window 4 and 1) on shared pins,
// checked every cycle against a sample-history reference model.
module tb_button_debouncer;

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] st;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] raw;

  logic [1:0] lvl4, pr4, rl4, st4;
  logic [1:0] lvl1, pr1, rl1, st1;

  int checks = 0;
  int errors = 0;

  pair_t q[$];

  always #5 clk = ~clk;

  button_debouncer #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (2'b11)
  ) dut4 (
    .clk           (clk),
    .reset_n       (reset_n),
    .button_raw    (raw),
    .button_level  (lvl4),
    .press_pulse   (pr4),
    .release_pulse (rl4),
    .settling      (st4)
  );

  button_debouncer #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (1),
    .RESET_VALUE     (2'b11)
  ) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .button_raw    (raw),
    .button_level  (lvl1),
    .press_pulse   (pr1),
    .release_pulse (rl1),
    .settling      (st1)
  );

  // Reference model: pin samples delayed two edges, then a level
  // flips once the last N samples all disagree with it.
  int         dcs [2] = '{4, 1};
  logic [1:0] m_s1;
  logic [1:0] m_s2;
  logic [1:0] m_lvl [2];
  logic [1:0] m_hist [2][8];

  task automatic model_reset();
    m_s1 = 2'b11;
    m_s2 = 2'b11;
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 2'b11;
      for (int i = 0; i < 8; i++) m_hist[k][i] = 2'b11;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin : model
    exp_t ex [2];
    exp_t r;
    int   run;
    if (!reset_n) begin
      model_reset();
      r = '{lvl: 2'b11, pr: 2'b00, rl: 2'b00, st: 2'b00};
      q.delete();
      q.push_back('{a: r, b: r});
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = m_s2;
        ex[k] = '0;
        for (int ch = 0; ch < 2; ch++) begin
          run = 0;
          while (run < dcs[k] && m_hist[k][run][ch] != m_lvl[k][ch])
            run++;
          if (run == dcs[k]) begin
            if (m_lvl[k][ch]) ex[k].pr[ch] = 1'b1;
            else              ex[k].rl[ch] = 1'b1;
            m_lvl[k][ch] = ~m_lvl[k][ch];
          end else begin
            ex[k].st[ch] = (run > 0);
          end
        end
        ex[k].lvl = m_lvl[k];
      end
      m_s2 = m_s1;
      m_s1 = raw;
      q.push_back('{a: ex[0], b: ex[1]});
    end
  end

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    pair_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("level4",   lvl4, e.a.lvl);
      chk("press4",   pr4,  e.a.pr);
      chk("release4", rl4,  e.a.rl);
      chk("settle4",  st4,  e.a.st);
      chk("level1",   lvl1, e.b.lvl);
      chk("press1",   pr1,  e.b.pr);
      chk("release1", rl1,  e.b.rl);
      chk("settle1",  st1,  e.b.st);
    end
  end

  task automatic drive(input logic [1:0] v, input int n);
    raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    raw     = 2'b00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(2'b00, 10);
    drive(2'b11, 10);
    drive(2'b10, 10);
    drive(2'b11, 10);
    drive(2'b10, 3);
    drive(2'b11, 3);
    drive(2'b10, 3);
    drive(2'b11, 3);
    drive(2'b10, 10);
    drive(2'b00, 10);
    drive(2'b01, 10);
    drive(2'b11, 10);
    drive(2'b00, 3);
    do_reset(2);
    drive(2'b00, 10);
    drive(2'b11, 10);
    drive(2'b10, 1);
    drive(2'b11, 10);
    repeat (300) begin
      if ($urandom_range(0, 40) == 0)
        do_reset(int'($urandom_range(1, 2)));
      else
        drive(2'($urandom), int'($urandom_range(1, 7)));
    end
    drive(raw, 8);
    checks++;
    if (q.size() > 1) begin
      errors++;
      $display("FAIL queue_drain got %0d expected <=1", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
